// File: rtl/flash_boot_loader_pkg.sv
// flash_boot_loader_pkg: state encodings and bus constants shared by the boot loader.
// The BOOT_VERIFY_EN macro (used in flash_boot_loader.sv) enables the BootVRd state.
package flash_boot_loader_pkg;

    // Boot sequencer states. BootVRd is only reachable when read-back verify is built in.
    typedef enum logic [2:0] {
        BootIdle  = 3'd0,
        BootFReq  = 3'd1,
        BootFWait = 3'd2,
        BootRWr   = 3'd3,
        BootRWait = 3'd4,
        BootVRd   = 3'd5,
        BootNext  = 3'd6,
        BootDone  = 3'd7
    } boot_state_e;

    // ram_readWrite_o encodings
    localparam logic RamWrite = 1'b1;
    localparam logic RamRead  = 1'b0;

    // Flash word address bus is flash_addr[22:1], i.e. 22 bits wide
    localparam int FLASH_AW = 22;

    // Width of a down-counter that must hold (max_wait - 1)
    function automatic int wait_timer_width(input int flash_wait, input int ram_wait);
        int m;
        m = (flash_wait > ram_wait) ? flash_wait : ram_wait;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/flash_boot_loader_timer.sv
// boot_wait_timer: loadable down-counter with a zero flag, shared by the flash,
// RAM write and RAM verify wait phases of flash_boot_loader.
module boot_wait_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: post-reset sequencer copying BOOT_WORDS words from flash into RAM2
// while holding the CPU. Optional macro BOOT_VERIFY_EN adds a read-back compare per word.
//
// Handshake: flash_read_o is held for FLASH_WAIT cycles and flash_data_i is captured on
// the last one; a RAM request (ram_enable_o with stable address/data/direction) is held
// for RAM_WAIT cycles and is complete when ram_enable_o drops. The two buses are never
// active in the same cycle.
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter int unsigned BOOT_WORDS = 512,
    parameter int unsigned FLASH_BASE = 0,
    parameter int unsigned RAM_BASE   = 0,
    parameter int unsigned RAM_AW     = 18,
    parameter int unsigned FLASH_WAIT = 4,
    parameter int unsigned RAM_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              skip_i,
    output logic [21:0]       flash_addr_o,
    output logic              flash_read_o,
    input  logic [15:0]       flash_data_i,
    output logic              ram_enable_o,
    output logic              ram_readWrite_o,
    output logic [RAM_AW-1:0] ram_address_o,
    output logic [15:0]       ram_data_o,
    input  logic [15:0]       ram_data_i,
    output logic              cpu_hold_o,
    output logic              boot_done_o,
    output logic              boot_error_o,
    output logic [RAM_AW-1:0] word_cnt_o
);

    localparam int TW = wait_timer_width(FLASH_WAIT, RAM_WAIT);
    localparam logic [TW-1:0]       FLASH_LOAD   = TW'(FLASH_WAIT - 1);
    localparam logic [TW-1:0]       RAM_LOAD     = TW'(RAM_WAIT - 1);
    localparam logic [FLASH_AW-1:0] FLASH_BASE_V = FLASH_AW'(FLASH_BASE);
    localparam logic [RAM_AW-1:0]   RAM_BASE_V   = RAM_AW'(RAM_BASE);
    // One extra bit so BOOT_WORDS == 2^RAM_AW is still reachable
    localparam logic [RAM_AW:0]     BOOT_WORDS_V = (RAM_AW + 1)'(BOOT_WORDS);

    boot_state_e          state_q;
    logic [RAM_AW-1:0]    word_cnt_q;
    logic [15:0]          data_q;
    logic [FLASH_AW-1:0]  flash_addr_q;
    logic                 flash_read_q;
    logic                 ram_en_q;
    logic                 ram_rw_q;
    logic [RAM_AW-1:0]    ram_addr_q;
    logic [15:0]          ram_data_q;
    logic                 cpu_hold_q;
    logic                 done_q;
    logic                 error_q;

    logic                 tmr_load;
    logic [TW-1:0]        tmr_load_val;
    logic                 tmr_dec;
    logic                 tmr_zero;

    logic [FLASH_AW-1:0]  flash_next;
    logic [RAM_AW-1:0]    ram_next;
    logic [RAM_AW:0]      cnt_inc;

`ifdef BOOT_VERIFY_EN
    // Low on the first V_RD cycle (request setup), high while the read is being held
    logic                 verify_armed_q;
`else
    // Read-back data only matters when verify is built in
    logic                 unused_ram_data;
    assign unused_ram_data = ^ram_data_i;
`endif

    // Word addresses wrap naturally at their bus widths
    assign flash_next = FLASH_BASE_V + FLASH_AW'(word_cnt_q);
    assign ram_next   = RAM_BASE_V + word_cnt_q;
    assign cnt_inc    = {1'b0, word_cnt_q} + 1'b1;

    // Timer control: load on entry to each wait phase, count down while waiting
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = FLASH_LOAD;
        tmr_dec      = 1'b0;
        case (state_q)
            BootFReq: begin
                tmr_load     = 1'b1;
                tmr_load_val = FLASH_LOAD;
            end
            BootRWr: begin
                tmr_load     = 1'b1;
                tmr_load_val = RAM_LOAD;
            end
            BootFWait, BootRWait: begin
                tmr_dec = 1'b1;
            end
`ifdef BOOT_VERIFY_EN
            BootVRd: begin
                if (!verify_armed_q) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = RAM_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    boot_wait_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Boot sequencer with every bus output registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= BootIdle;
            word_cnt_q   <= '0;
            data_q       <= '0;
            flash_addr_q <= FLASH_BASE_V;
            flash_read_q <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_rw_q     <= RamRead;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef BOOT_VERIFY_EN
            verify_armed_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                BootIdle: begin
                    if (skip_i) begin
                        state_q      <= BootDone;
                        flash_addr_q <= '0;
                        cpu_hold_q   <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        state_q <= BootFReq;
                    end
                end
                BootFReq: begin
                    flash_addr_q <= flash_next;
                    flash_read_q <= 1'b1;
                    state_q      <= BootFWait;
                end
                BootFWait: begin
                    if (tmr_zero) begin
                        data_q       <= flash_data_i;
                        flash_read_q <= 1'b0;
                        state_q      <= BootRWr;
                    end
                end
                BootRWr: begin
                    ram_en_q   <= 1'b1;
                    ram_rw_q   <= RamWrite;
                    ram_addr_q <= ram_next;
                    ram_data_q <= data_q;
                    state_q    <= BootRWait;
                end
                BootRWait: begin
                    if (tmr_zero) begin
                        ram_en_q <= 1'b0;
                        ram_rw_q <= RamRead;
`ifdef BOOT_VERIFY_EN
                        verify_armed_q <= 1'b0;
                        state_q        <= BootVRd;
`else
                        state_q        <= BootNext;
`endif
                    end
                end
`ifdef BOOT_VERIFY_EN
                BootVRd: begin
                    if (!verify_armed_q) begin
                        ram_en_q       <= 1'b1;
                        ram_rw_q       <= RamRead;
                        verify_armed_q <= 1'b1;
                    end else if (tmr_zero) begin
                        ram_en_q       <= 1'b0;
                        verify_armed_q <= 1'b0;
                        if (ram_data_i != data_q) begin
                            // Bad image: flag it and stop, but never release the CPU
                            state_q      <= BootDone;
                            error_q      <= 1'b1;
                            done_q       <= 1'b1;
                            flash_addr_q <= '0;
                            ram_addr_q   <= '0;
                            ram_data_q   <= '0;
                        end else begin
                            state_q <= BootNext;
                        end
                    end
                end
`endif
                BootNext: begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                    if (cnt_inc == BOOT_WORDS_V) begin
                        state_q      <= BootDone;
                        flash_addr_q <= '0;
                        ram_addr_q   <= '0;
                        ram_data_q   <= '0;
                        cpu_hold_q   <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        state_q <= BootFReq;
                    end
                end
                default: begin
                    // BootDone is terminal until reset
                end
            endcase
        end
    end

    assign flash_addr_o    = flash_addr_q;
    assign flash_read_o    = flash_read_q;
    assign ram_enable_o    = ram_en_q;
    assign ram_readWrite_o = ram_rw_q;
    assign ram_address_o   = ram_addr_q;
    assign ram_data_o      = ram_data_q;
    assign cpu_hold_o      = cpu_hold_q;
    assign boot_done_o     = done_q;
    assign boot_error_o    = error_q;
    assign word_cnt_o      = word_cnt_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: directed bench for flash_boot_loader with a latency-aware flash
// model and a RAM model that commits a write only after the full RAM_WAIT hold.
module tb_flash_boot_loader;

    localparam int          BW = 4;
    localparam logic [21:0] FB = 22'h000020;
    localparam logic [17:0] RB = 18'h3FFFE;
    localparam int          FW = 2;
    localparam int          RW = 2;
`ifdef BOOT_VERIFY_EN
    localparam int PER_WORD = 10;  // (2+1)+(2+1)+1+(2+1)
`else
    localparam int PER_WORD = 7;   // (2+1)+(2+1)+1
`endif
    localparam int EXP_DONE = BW * PER_WORD + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        skip_i;
    logic [21:0] flash_addr_o;
    logic        flash_read_o;
    logic [15:0] flash_data_i;
    logic        ram_enable_o;
    logic        ram_readWrite_o;
    logic [17:0] ram_address_o;
    logic [15:0] ram_data_o;
    logic [15:0] ram_data_i;
    logic        cpu_hold_o;
    logic        boot_done_o;
    logic        boot_error_o;
    logic [17:0] word_cnt_o;

    flash_boot_loader #(
        .BOOT_WORDS (BW),
        .FLASH_BASE (32'h20),
        .RAM_BASE   (32'h3FFFE),
        .RAM_AW     (18),
        .FLASH_WAIT (FW),
        .RAM_WAIT   (RW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .skip_i          (skip_i),
        .flash_addr_o    (flash_addr_o),
        .flash_read_o    (flash_read_o),
        .flash_data_i    (flash_data_i),
        .ram_enable_o    (ram_enable_o),
        .ram_readWrite_o (ram_readWrite_o),
        .ram_address_o   (ram_address_o),
        .ram_data_o      (ram_data_o),
        .ram_data_i      (ram_data_i),
        .cpu_hold_o      (cpu_hold_o),
        .boot_done_o     (boot_done_o),
        .boot_error_o    (boot_error_o),
        .word_cnt_o      (word_cnt_o)
    );

    // ---------------- scoreboard state ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    int          f_age = 0;
    int          r_age = 0;
    int          flash_pulses = 0;
    int          ram_pulses   = 0;
    bit          corrupt_en   = 1'b0;
    logic [15:0] mem [logic [17:0]];
    logic [17:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [21:0] rd_addr_q [$];
    logic        prev_read = 1'b0;
    logic        prev_en   = 1'b0;
    logic        prev_rw   = 1'b0;
    logic [17:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    // Flash data is only valid once the strobe has been held FLASH_WAIT cycles
    assign flash_data_i = (flash_read_o && (f_age >= FW)) ? (16'hA000 + flash_addr_o[15:0]) : 16'hBAD0;

    // Bus monitor and RAM model, sampled mid-cycle
    always @(negedge clk) begin
        if (flash_read_o && !prev_read) begin
            flash_pulses++;
            rd_addr_q.push_back(flash_addr_o);
        end
        if (ram_enable_o && !prev_en) ram_pulses++;
        f_age = flash_read_o ? f_age + 1 : 0;
        if (ram_enable_o) begin
            r_age++;
            if (r_age == RW && ram_readWrite_o) begin
                mem[ram_address_o] = ram_data_o;
                wr_addr_q.push_back(ram_address_o);
                wr_data_q.push_back(ram_data_o);
            end
        end else begin
            r_age = 0;
        end
        if (corrupt_en && ram_address_o == RB + 18'd1) ram_data_i = 16'hDEAD;
        else if (mem.exists(ram_address_o)) ram_data_i = mem[ram_address_o];
        else ram_data_i = 16'h0000;
        if (flash_read_o || ram_enable_o) begin
            tests_run++;
            if (flash_read_o && ram_enable_o) begin
                tests_failed++;
                $display("FAIL bus_excl: flash_read_o=1 and ram_enable_o=1 together, required never both");
            end
        end
        if (ram_enable_o && prev_en) begin
            tests_run++;
            if (ram_address_o !== prev_addr || ram_data_o !== prev_data || ram_readWrite_o !== prev_rw) begin
                tests_failed++;
                $display("FAIL ram_stable: addr/data/rw %h/%h/%b, required %h/%h/%b",
                         ram_address_o, ram_data_o, ram_readWrite_o, prev_addr, prev_data, prev_rw);
            end
        end
        prev_read = flash_read_o;
        prev_en   = ram_enable_o;
        prev_rw   = ram_readWrite_o;
        prev_addr = ram_address_o;
        prev_data = ram_data_o;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst    = 1'b0;
        skip_i = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        mem.delete();
        flash_pulses = 0;
        ram_pulses   = 0;
    endtask

    // Releases reset and returns the cycle index at which boot_done_o is first seen (0 on timeout)
    task automatic run_to_done(output int cyc, output logic hold_before);
        cyc = 0;
        hold_before = 1'b0;
        rst = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (boot_done_o) begin
                cyc = k;
                break;
            end
            hold_before = cpu_hold_o;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run += 10;
        if (cpu_hold_o !== 1'b1)      begin tests_failed++; $display("FAIL rst_hold: got %b, required 1", cpu_hold_o); end
        if (boot_done_o !== 1'b0)     begin tests_failed++; $display("FAIL rst_done: got %b, required 0", boot_done_o); end
        if (boot_error_o !== 1'b0)    begin tests_failed++; $display("FAIL rst_error: got %b, required 0", boot_error_o); end
        if (flash_read_o !== 1'b0)    begin tests_failed++; $display("FAIL rst_fread: got %b, required 0", flash_read_o); end
        if (ram_enable_o !== 1'b0)    begin tests_failed++; $display("FAIL rst_ren: got %b, required 0", ram_enable_o); end
        if (ram_readWrite_o !== 1'b0) begin tests_failed++; $display("FAIL rst_rw: got %b, required 0", ram_readWrite_o); end
        if (ram_address_o !== 18'h0)  begin tests_failed++; $display("FAIL rst_raddr: got %h, required 0", ram_address_o); end
        if (ram_data_o !== 16'h0)     begin tests_failed++; $display("FAIL rst_rdata: got %h, required 0", ram_data_o); end
        if (flash_addr_o !== FB)      begin tests_failed++; $display("FAIL rst_faddr: got %h, required %h", flash_addr_o, FB); end
        if (word_cnt_o !== 18'h0)     begin tests_failed++; $display("FAIL rst_cnt: got %h, required 0", word_cnt_o); end
    endtask

    task automatic test_copy();
        int   cyc;
        logic hb;
        logic [17:0] ea;
        do_reset();
        run_to_done(cyc, hb);
        tests_run += 10;
        if (cyc != EXP_DONE)       begin tests_failed++; $display("FAIL copy_latency: done at cycle %0d, required %0d", cyc, EXP_DONE); end
        if (cpu_hold_o !== 1'b0)   begin tests_failed++; $display("FAIL copy_hold: got %b, required 0", cpu_hold_o); end
        if (hb !== 1'b1)           begin tests_failed++; $display("FAIL copy_hold_prev: got %b, required 1", hb); end
        if (word_cnt_o !== 18'd4)  begin tests_failed++; $display("FAIL copy_cnt: got %0d, required 4", word_cnt_o); end
        if (boot_error_o !== 1'b0) begin tests_failed++; $display("FAIL copy_err: got %b, required 0", boot_error_o); end
        if (wr_addr_q.size() != BW) begin tests_failed++; $display("FAIL copy_nwr: got %0d writes, required %0d", wr_addr_q.size(), BW); end
        if (rd_addr_q.size() != BW) begin tests_failed++; $display("FAIL copy_nrd: got %0d reads, required %0d", rd_addr_q.size(), BW); end
        if (flash_addr_o !== 22'h0 || flash_read_o !== 1'b0) begin
            tests_failed++; $display("FAIL copy_done_flash: addr=%h rd=%b, required 0/0", flash_addr_o, flash_read_o);
        end
        if (ram_enable_o !== 1'b0 || ram_readWrite_o !== 1'b0) begin
            tests_failed++; $display("FAIL copy_done_ren: en=%b rw=%b, required 0/0", ram_enable_o, ram_readWrite_o);
        end
        if (ram_address_o !== 18'h0 || ram_data_o !== 16'h0) begin
            tests_failed++; $display("FAIL copy_done_rbus: addr=%h data=%h, required 0/0", ram_address_o, ram_data_o);
        end
        for (int i = 0; i < BW; i++) begin
            ea = RB + 18'(i);  // 3FFFE, 3FFFF, 00000, 00001
            tests_run += 3;
            if (i >= wr_addr_q.size()) begin
                tests_failed += 2; $display("FAIL copy_wr%0d: write missing, required %h<=%h", i, ea, 16'hA020 + 16'(i));
            end else begin
                if (wr_addr_q[i] !== ea) begin tests_failed++; $display("FAIL copy_waddr%0d: got %h, required %h", i, wr_addr_q[i], ea); end
                if (wr_data_q[i] !== 16'hA020 + 16'(i)) begin
                    tests_failed++; $display("FAIL copy_wdata%0d: got %h, required %h", i, wr_data_q[i], 16'hA020 + 16'(i));
                end
            end
            if (i >= rd_addr_q.size()) begin
                tests_failed++; $display("FAIL copy_faddr%0d: read missing, required %h", i, FB + 22'(i));
            end else if (rd_addr_q[i] !== FB + 22'(i)) begin
                tests_failed++; $display("FAIL copy_faddr%0d: got %h, required %h", i, rd_addr_q[i], FB + 22'(i));
            end
        end
    endtask

    task automatic test_skip();
        do_reset();
        skip_i = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        skip_i = 1'b0;
        tests_run += 3;
        if (boot_done_o !== 1'b1) begin tests_failed++; $display("FAIL skip_done: got %b, required 1", boot_done_o); end
        if (cpu_hold_o !== 1'b0)  begin tests_failed++; $display("FAIL skip_hold: got %b, required 0", cpu_hold_o); end
        if (word_cnt_o !== 18'h0) begin tests_failed++; $display("FAIL skip_cnt: got %h, required 0", word_cnt_o); end
        repeat (20) @(negedge clk);
        tests_run += 3;
        if (flash_pulses != 0)    begin tests_failed++; $display("FAIL skip_fpulse: got %0d, required 0", flash_pulses); end
        if (ram_pulses != 0)      begin tests_failed++; $display("FAIL skip_rpulse: got %0d, required 0", ram_pulses); end
        if (boot_done_o !== 1'b1) begin tests_failed++; $display("FAIL skip_sticky: got %b, required 1", boot_done_o); end
    endtask

    task automatic test_mid_reset();
        int   cyc;
        logic hb;
        bit   hit;
        do_reset();
        rst = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (word_cnt_o == 18'd2 && ram_enable_o && ram_readWrite_o) begin
                hit = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!hit) begin tests_failed++; $display("FAIL mid_reach: R_WAIT of word 2 not seen, required within 200 cycles"); end
        rst = 1'b0;
        @(negedge clk);
        tests_run += 6;
        if (cpu_hold_o !== 1'b1)     begin tests_failed++; $display("FAIL mid_hold: got %b, required 1", cpu_hold_o); end
        if (ram_enable_o !== 1'b0)   begin tests_failed++; $display("FAIL mid_ren: got %b, required 0", ram_enable_o); end
        if (ram_address_o !== 18'h0) begin tests_failed++; $display("FAIL mid_raddr: got %h, required 0", ram_address_o); end
        if (ram_data_o !== 16'h0)    begin tests_failed++; $display("FAIL mid_rdata: got %h, required 0", ram_data_o); end
        if (word_cnt_o !== 18'h0)    begin tests_failed++; $display("FAIL mid_cnt: got %h, required 0", word_cnt_o); end
        if (flash_addr_o !== FB)     begin tests_failed++; $display("FAIL mid_faddr: got %h, required %h", flash_addr_o, FB); end
        rd_addr_q.delete();
        run_to_done(cyc, hb);
        tests_run += 3;
        if (rd_addr_q.size() == 0)   begin tests_failed++; $display("FAIL mid_restart: no flash read, required first at %h", FB); end
        else if (rd_addr_q[0] !== FB) begin tests_failed++; $display("FAIL mid_restart: got %h, required %h", rd_addr_q[0], FB); end
        if (cyc != EXP_DONE)         begin tests_failed++; $display("FAIL mid_latency: done at cycle %0d, required %0d", cyc, EXP_DONE); end
        if (word_cnt_o !== 18'd4)    begin tests_failed++; $display("FAIL mid_cnt_end: got %0d, required 4", word_cnt_o); end
    endtask

`ifdef BOOT_VERIFY_EN
    task automatic test_verify();
        int   cyc;
        logic hb;
        do_reset();
        corrupt_en = 1'b1;
        run_to_done(cyc, hb);
        corrupt_en = 1'b0;
        tests_run += 5;
        if (cyc == 0)              begin tests_failed++; $display("FAIL ver_timeout: boot_done_o never rose, required within 300 cycles"); end
        if (boot_error_o !== 1'b1) begin tests_failed++; $display("FAIL ver_err: got %b, required 1", boot_error_o); end
        if (cpu_hold_o !== 1'b1)   begin tests_failed++; $display("FAIL ver_hold: got %b, required 1", cpu_hold_o); end
        if (word_cnt_o !== 18'd1)  begin tests_failed++; $display("FAIL ver_cnt: got %0d, required 1", word_cnt_o); end
        if (ram_enable_o !== 1'b0) begin tests_failed++; $display("FAIL ver_ren: got %b, required 0", ram_enable_o); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst    = 1'b0;
        skip_i = 1'b0;
        test_reset();
        test_copy();
        test_skip();
        test_mid_reset();
`ifdef BOOT_VERIFY_EN
        test_verify();
`endif
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
